// File: rtl/vsimd_pkg.sv
// ---------------------------------------------------------------------------
// vsimd_pkg
// Shared types and constants for the SIMD FIR vector datapath.
//
// Contents:
//   LANES, LANE_W, ADDR_W  - vector geometry and memory address width
//   lane_idx_t             - lane index, $clog2(LANES) bits
//   packed_vec_t           - packed vector, lane i = bits [i*LANE_W +: LANE_W]
//                            (same layout as the ALU result packer output)
//   lane_mask_t            - one enable bit per lane
//   vstore_state_t         - store serializer states (IDLE, WRITE, DONE)
//   next_active_lane()     - lowest enabled lane at or above a start index
// ---------------------------------------------------------------------------
package vsimd_pkg;

  localparam int LANES      = 16;
  localparam int LANE_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int LANE_IDX_W = $clog2(LANES);

  typedef logic [LANE_IDX_W-1:0]   lane_idx_t;
  typedef logic [LANES*LANE_W-1:0] packed_vec_t;
  typedef logic [LANES-1:0]        lane_mask_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } vstore_state_t;

  typedef struct packed {
    logic      found;
    lane_idx_t idx;
  } lane_pick_t;

  // Scans from the top down so the lowest enabled lane >= start wins.
  // A start index of LANES finds nothing, which is how the last lane is detected.
  function automatic lane_pick_t next_active_lane(input lane_mask_t mask, input int start);
    lane_pick_t pick;
    pick.found = 1'b0;
    pick.idx   = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if ((i >= start) && mask[i]) begin
        pick.found = 1'b1;
        pick.idx   = lane_idx_t'(i);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/vec_lane_mux.sv
// ---------------------------------------------------------------------------
// vec_lane_mux
// Combinational selection of one lane from a packed vector.
//
// Ports:
//   vec   in   packed_vec_t   packed vector
//   sel   in   lane_idx_t     lane index to select
//   lane  out  LANE_W bits    selected lane
// ---------------------------------------------------------------------------
module vec_lane_mux
  import vsimd_pkg::*;
(
  input  packed_vec_t       vec,
  input  lane_idx_t         sel,
  output logic [LANE_W-1:0] lane
);

  // Two-dimensional view keeps the select a plain array index.
  logic [LANES-1:0][LANE_W-1:0] lanes;

  assign lanes = vec;
  assign lane  = lanes[sel];

endmodule

// File: rtl/vec_store_serializer.sv
// ---------------------------------------------------------------------------
// vec_store_serializer
// Streams a packed vector to the 32-bit data-memory write port as one word
// write per lane, starting at a byte base address, then pulses done.
//
// Parameters:
//   ADDR_STEP  byte increment between consecutive lanes (default 4)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   packed vector and base address valid
//   in_ready   out  block can accept a new store (IDLE)
//   in_data    in   packed vector, lane i = bits [i*LANE_W +: LANE_W]
//   in_base    in   byte address of lane 0
//   in_mask    in   lane enables (only with VSTORE_LANE_MASK_EN)
//   mem_we     out  write strobe
//   mem_addr   out  write address (registered)
//   mem_wdata  out  write data (registered)
//   mem_ready  in   memory accepts the current write this cycle
//   busy       out  store in progress (WRITE or DONE)
//   done       out  one-cycle pulse after the last lane is accepted
//
// Optional feature: define VSTORE_LANE_MASK_EN to add in_mask; disabled lanes
// get no write cycle and an all-zero mask goes straight to DONE.
// ---------------------------------------------------------------------------
module vec_store_serializer
  import vsimd_pkg::*;
#(
  parameter int unsigned ADDR_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  packed_vec_t       in_data,
  input  logic [ADDR_W-1:0] in_base,
`ifdef VSTORE_LANE_MASK_EN
  input  lane_mask_t        in_mask,
`endif
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LANE_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done
);

  vstore_state_t     state, state_next;
  lane_idx_t         lane_q, lane_next;
  packed_vec_t       data_q;
  logic [ADDR_W-1:0] base_q;
  lane_mask_t        mask_q;
  lane_mask_t        accept_mask;
  logic              load_word;
  lane_pick_t        pick;

  packed_vec_t       sel_vec;
  logic [ADDR_W-1:0] sel_base;
  logic [ADDR_W-1:0] lane_offset;
  logic [LANE_W-1:0] lane_word;

`ifdef VSTORE_LANE_MASK_EN
  assign accept_mask = in_mask;

  // Mask is captured together with the vector and never re-sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
    end else if ((state == IDLE) && in_valid) begin
      mask_q <= in_mask;
    end
  end
`else
  assign accept_mask = '1;
  assign mask_q      = '1;
`endif

  // State register plus the held store context and registered memory outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lane_q    <= '0;
      data_q    <= '0;
      base_q    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state  <= state_next;
      lane_q <= lane_next;
      if ((state == IDLE) && in_valid) begin
        data_q <= in_data;
        base_q <= in_base;
      end
      if (load_word) begin
        mem_addr  <= sel_base + lane_offset;
        mem_wdata <= lane_word;
      end
    end
  end

  // Next state and next lane. load_word marks edges where a new word is
  // presented; otherwise address and data hold (including while stalled).
  always_comb begin
    state_next = state;
    lane_next  = lane_q;
    load_word  = 1'b0;
    pick       = '0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          pick = next_active_lane(accept_mask, 0);
          if (pick.found) begin
            state_next = WRITE;
            lane_next  = pick.idx;
            load_word  = 1'b1;
          end else begin
            state_next = DONE;
          end
        end
      end
      WRITE: begin
        if (mem_ready) begin
          pick = next_active_lane(mask_q, int'(lane_q) + 1);
          if (pick.found) begin
            lane_next = pick.idx;
            load_word = 1'b1;
          end else begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // On acceptance the first word comes straight from the inputs, since the
  // held registers are only being loaded at that same edge.
  assign sel_vec     = (state == IDLE) ? in_data : data_q;
  assign sel_base    = (state == IDLE) ? in_base : base_q;
  assign lane_offset = ADDR_W'(ADDR_W'(lane_next) * ADDR_W'(ADDR_STEP));

  vec_lane_mux u_lane_mux (
    .vec  (sel_vec),
    .sel  (lane_next),
    .lane (lane_word)
  );

  // Status outputs decode directly from the registered state.
  always_comb begin
    in_ready = (state == IDLE);
    mem_we   = (state == WRITE);
    busy     = (state == WRITE) || (state == DONE);
    done     = (state == DONE);
  end

endmodule

// File: tb/tb_vec_store_serializer.sv
// ---------------------------------------------------------------------------
// tb_vec_store_serializer
// Directed bench for vec_store_serializer with a write scoreboard: expected
// (address, data) pairs are queued when a store is driven and popped by a
// monitor whenever the DUT completes a memory write.
// Define VSTORE_LANE_MASK_EN to also exercise the lane-mask feature.
// ---------------------------------------------------------------------------
module tb_vec_store_serializer;
  import vsimd_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  packed_vec_t       in_data;
  logic [ADDR_W-1:0] in_base;
`ifdef VSTORE_LANE_MASK_EN
  lane_mask_t        in_mask;
`endif
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LANE_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              busy;
  logic              done;

  int checks      = 0;
  int errors      = 0;
  int cyc         = 0;
  int write_count = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [LANE_W-1:0] data;
  } exp_write_t;

  exp_write_t sb[$];

  vec_store_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_base   (in_base),
`ifdef VSTORE_LANE_MASK_EN
    .in_mask   (in_mask),
`endif
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Scoreboard monitor: a write completes at the next rising edge when
  // mem_we and mem_ready are both high, sampled here on the falling edge.
  always @(negedge clk) begin
    if (!rst && mem_we && mem_ready) begin
      write_count++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("[TB] FAIL unexpected_write observed=addr 0x%0h expected=no write", mem_addr);
      end
      if (sb.size() != 0) begin
        exp_write_t e;
        e = sb.pop_front();
        checkOutput("sb_addr", mem_addr, e.addr);
        checkOutput("sb_data", mem_wdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic packed_vec_t make_vec(input logic [LANE_W-1:0] first);
    packed_vec_t v;
    for (int i = 0; i < LANES; i++) v[i*LANE_W +: LANE_W] = first + LANE_W'(i);
    return v;
  endfunction

  // Reference model of one store: every enabled lane i writes lane i to
  // base + i*4, modulo 2^32.
  task automatic push_expect(input packed_vec_t vec, input logic [ADDR_W-1:0] base, input lane_mask_t mask);
    exp_write_t e;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) begin
        e.addr = base + ADDR_W'(i * 4);
        e.data = vec[i*LANE_W +: LANE_W];
        sb.push_back(e);
      end
    end
  endtask

  // Drives a store and returns in the first cycle after acceptance.
  task automatic applyStimulus(input packed_vec_t vec, input logic [ADDR_W-1:0] base,
                               input lane_mask_t mask, input bit hold_valid, output int accept_cyc);
    int   n;
    logic ready_seen;
    in_data  = vec;
    in_base  = base;
`ifdef VSTORE_LANE_MASK_EN
    in_mask  = mask;
`endif
    in_valid = 1'b1;
    push_expect(vec, base, mask);
    n = 0;
    do begin
      ready_seen = in_ready;
      tick();
      n++;
    end while (!ready_seen && n < 50);
    checkOutput("accept_seen", ready_seen, 1'b1);
    accept_cyc = cyc;
    if (!hold_valid) in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int done_cyc);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    checkOutput("done_seen", done, 1'b1);
    done_cyc = cyc;
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_in_ready"}, in_ready, 1'b1);
    checkOutput({tag, "_mem_we"}, mem_we, 1'b0);
    checkOutput({tag, "_mem_addr"}, mem_addr, '0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata, '0);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    int t0;
    int td;
    int wc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_base   = '0;
    mem_ready = 1'b1;
`ifdef VSTORE_LANE_MASK_EN
    in_mask   = '0;
`endif
    tick();
    tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();

    $display("[TB] basic store, base 0x100");
    applyStimulus(make_vec(32'h1000_0000), 32'h100, '1, 1'b0, t0);
    checkOutput("t1_first_addr", mem_addr, 32'h100);
    checkOutput("t1_first_data", mem_wdata, 32'h1000_0000);
    checkOutput("t1_first_we", mem_we, 1'b1);
    checkOutput("t1_busy", busy, 1'b1);
    checkOutput("t1_not_ready", in_ready, 1'b0);
    wait_done(40, td);
    checkOutput("t1_done_latency", td - t0, 16);
    checkOutput("t1_done_we", mem_we, 1'b0);
    checkOutput("t1_done_busy", busy, 1'b1);
    tick();
    checkOutput("t1_ready_after", in_ready, 1'b1);
    checkOutput("t1_done_pulse", done, 1'b0);
    checkOutput("t1_sb_empty", sb.size(), 0);

    $display("[TB] stall for 3 cycles on lane 5");
    applyStimulus(make_vec(32'h1000_0000), 32'h100, '1, 1'b0, t0);
    repeat (5) tick();
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput("t2_stall_addr", mem_addr, 32'h114);
      checkOutput("t2_stall_data", mem_wdata, 32'h1000_0005);
      checkOutput("t2_stall_we", mem_we, 1'b1);
      tick();
    end
    mem_ready = 1'b1;
    checkOutput("t2_release_addr", mem_addr, 32'h114);
    checkOutput("t2_release_data", mem_wdata, 32'h1000_0005);
    wait_done(40, td);
    checkOutput("t2_done_latency", td - t0, 19);
    tick();
    checkOutput("t2_sb_empty", sb.size(), 0);

    $display("[TB] address wrap, base 0xFFFFFFF8");
    applyStimulus(make_vec(32'hA000_0000), 32'hFFFF_FFF8, '1, 1'b0, t0);
    checkOutput("t3_lane0_addr", mem_addr, 32'hFFFF_FFF8);
    tick();
    checkOutput("t3_lane1_addr", mem_addr, 32'hFFFF_FFFC);
    tick();
    checkOutput("t3_lane2_addr", mem_addr, 32'h0000_0000);
    checkOutput("t3_lane2_data", mem_wdata, 32'hA000_0002);
    repeat (13) tick();
    checkOutput("t3_lane15_addr", mem_addr, 32'h0000_0034);
    wait_done(40, td);
    checkOutput("t3_done_latency", td - t0, 16);
    tick();

    $display("[TB] reset during lane 7");
    applyStimulus(make_vec(32'h2000_0000), 32'h100, '1, 1'b0, t0);
    repeat (7) tick();
    checkOutput("t4_lane7_addr", mem_addr, 32'h11C);
    rst = 1'b1;
    tick();
    check_reset_values("t4_after_rst");
    rst = 1'b0;
    checkOutput("t4_lanes_left", sb.size(), 9);
    sb.delete();
    wc = write_count;
    for (int k = 0; k < 3; k++) begin
      checkOutput("t4_no_done", done, 1'b0);
      tick();
    end
    checkOutput("t4_no_writes", write_count, wc);
    applyStimulus(make_vec(32'h3000_0000), 32'h200, '1, 1'b0, t0);
    checkOutput("t4_restart_addr", mem_addr, 32'h200);
    checkOutput("t4_restart_data", mem_wdata, 32'h3000_0000);
    wait_done(40, td);
    checkOutput("t4_done_latency", td - t0, 16);
    tick();
    checkOutput("t4_sb_empty", sb.size(), 0);

    $display("[TB] in_valid held high with changing data");
    applyStimulus(make_vec(32'h4000_0000), 32'h400, '1, 1'b1, t0);
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < LANES; i++) in_data[i*LANE_W +: LANE_W] = $urandom();
      in_base = $urandom();
      tick();
    end
    in_data = make_vec(32'h5000_0000);
    in_base = 32'h500;
    push_expect(in_data, in_base, '1);
    wait_done(40, td);
    checkOutput("t5_done_latency", td - t0, 16);
    tick();
    checkOutput("t5_ready_after_done", in_ready, 1'b1);
    tick();
    checkOutput("t5_second_period", cyc - t0, 18);
    checkOutput("t5_second_addr", mem_addr, 32'h500);
    checkOutput("t5_second_data", mem_wdata, 32'h5000_0000);
    in_valid = 1'b0;
    wait_done(40, td);
    tick();
    checkOutput("t5_sb_empty", sb.size(), 0);

`ifdef VSTORE_LANE_MASK_EN
    $display("[TB] lane mask 0x0005");
    applyStimulus(make_vec(32'h6000_0000), 32'h0, 16'h0005, 1'b0, t0);
    checkOutput("m1_lane0_addr", mem_addr, 32'h0);
    checkOutput("m1_lane0_data", mem_wdata, 32'h6000_0000);
    tick();
    checkOutput("m1_lane2_addr", mem_addr, 32'h8);
    checkOutput("m1_lane2_data", mem_wdata, 32'h6000_0002);
    checkOutput("m1_lane2_we", mem_we, 1'b1);
    tick();
    checkOutput("m1_done", done, 1'b1);
    checkOutput("m1_done_we", mem_we, 1'b0);
    tick();
    checkOutput("m1_sb_empty", sb.size(), 0);

    $display("[TB] lane mask all zero");
    wc = write_count;
    applyStimulus(make_vec(32'h7000_0000), 32'h0, 16'h0000, 1'b0, t0);
    checkOutput("m2_done", done, 1'b1);
    checkOutput("m2_we", mem_we, 1'b0);
    checkOutput("m2_busy", busy, 1'b1);
    tick();
    checkOutput("m2_ready", in_ready, 1'b1);
    checkOutput("m2_no_writes", write_count, wc);
`endif

    repeat (2) tick();
    checkOutput("final_sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_store_serializer.md
Name: vec_store_serializer

Overview:
- Downstream of the 16-lane ALU result packer; consumes its 512-bit packed vector (lane 0 in bits [31:0]).
- Streams the vector to the 32-bit data-memory write port as 16 sequential word writes starting at a base address.
- Used for vector store instructions in the SIMD FIR datapath; reports completion to the control unit.

Parameters:
- LANES, 16, number of 32-bit lanes in the packed vector
- LANE_W, 32, bits per lane and memory data width
- ADDR_W, 32, memory address width
- ADDR_STEP, 4, byte increment between consecutive lanes

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  packed vector and base address valid
- in_ready  output  1  block can accept a new store
- in_data  input  LANES*LANE_W  packed vector, lane i = bits [i*LANE_W +: LANE_W]
- in_base  input  ADDR_W  byte address of lane 0
- mem_we  output  1  write strobe to data memory
- mem_addr  output  ADDR_W  write address
- mem_wdata  output  LANE_W  write data
- mem_ready  input  1  memory accepts the current write this cycle
- busy  output  1  store in progress (WRITE or DONE)
- done  output  1  one-cycle pulse after last lane accepted

Behaviour:
- Single clock; reset synchronous, active-high.
- Reset: state=IDLE, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, lane counter=0, data register=0.
- States: IDLE, WRITE, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready at edge T, register in_data and in_base, set lane=0, go to WRITE. in_data and in_base are not sampled afterwards.
- WRITE: in_ready=0, busy=1, mem_we=1.
  - mem_addr = base + lane*ADDR_STEP, computed modulo 2^ADDR_W (wrap-around allowed, no error).
  - mem_wdata = lane 'lane' of the held vector.
  - Outputs are registered, so lane 0 appears the cycle after acceptance (T+1).
- Write handshake: a write completes at an edge where mem_we&&mem_ready.
  - Completed and lane<LANES-1: lane increments, next word presented.
  - Completed and lane==LANES-1: go to DONE, mem_we=0.
  - mem_ready=0: hold addr, data and we stable, no advance.
- DONE: done=1 for exactly one cycle, busy=1, in_ready=0, mem_we=0; next state IDLE.
- Minimum latency: 16 write cycles plus 1 DONE cycle. Back-to-back acceptance is possible the cycle after DONE, giving an 18-cycle minimum period.
- in_valid while not in IDLE: ignored; the producer must hold in_valid until in_ready.
- Reset asserted mid-store: immediate return to reset values at that edge; remaining lanes are not written; no done pulse.
- Lane counter width: $clog2(LANES).
- ADDR_STEP product is truncated to ADDR_W.

Optional Feature:
- Macro: VSTORE_LANE_MASK_EN.
- Defined:
  - Adds input in_mask [LANES-1:0], registered with in_data on acceptance.
  - In WRITE, lanes with mask bit 0 are skipped: no write cycle, addresses of later lanes unchanged (base + i*ADDR_STEP).
  - All-zero mask: WRITE is bypassed and the block goes straight from acceptance to DONE.
- Undefined: no in_mask port; all lanes are written.

Decomposition:
- Shared package vsimd_pkg:
  - LANES, LANE_W, ADDR_W constants.
  - Lane-index typedef.
  - State enum (IDLE, WRITE, DONE).
  - Packed-vector typedef, identical to the packer output type.
- Sub-module vec_lane_mux: combinational selection of one LANE_W slice from the held vector by lane index, isolating the wide mux from the FSM.

Test Plan:
- Reset, then in_data lane i = 32'h1000_0000+i, in_base=0x100, mem_ready=1:
  - addresses 0x100, 0x104, …, 0x13C with data 0x1000_0000…0x1000_000F on cycles T+1…T+16.
  - done pulse at T+17; in_ready=1 at T+18.
- Same store, mem_ready=0 for 3 cycles during lane 5:
  - addr 0x114 and data 0x1000_0005 held stable for 4 cycles.
  - Total completion delayed by exactly 3 cycles.
- in_base=0xFFFF_FFF8:
  - lanes 0,1 at 0xFFFF_FFF8 and 0xFFFF_FFFC; lane 2 wraps to 0x0000_0000; lane 15 at 0x34.
- Assert rst at lane 7:
  - next cycle all outputs at reset values, no done pulse.
  - A new store afterwards starts at lane 0.
- in_valid held high continuously with changing in_data after acceptance:
  - only the first vector is written; the second is accepted the cycle after DONE.
- With VSTORE_LANE_MASK_EN and in_mask=16'h0005, base 0:
  - writes only to 0x0 and 0x8 on consecutive cycles, then done.
  - in_mask=0 yields done at T+1 with no mem_we.
